// File: rtl/ace_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer taking up to four
// instructions per cycle and presenting the oldest four to a four-wide decoder.
`ifndef SIZE_AFTER_FETCH
`define SIZE_AFTER_FETCH 31
`endif

module ace_fetch_queue #(
   parameter int FW    = `SIZE_AFTER_FETCH + 1,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fq_flush,
   input  logic [3:0]               fq_in_valid,
   input  logic [FW-1:0]            fq_in_inst0,
   input  logic [FW-1:0]            fq_in_inst1,
   input  logic [FW-1:0]            fq_in_inst2,
   input  logic [FW-1:0]            fq_in_inst3,
   output logic                     fq_ready,
   input  logic                     dec_ready,
   output logic [3:0]               dec_valid,
   output logic [FW-1:0]            dec_inst0,
   output logic [FW-1:0]            dec_inst1,
   output logic [FW-1:0]            dec_inst2,
   output logic [FW-1:0]            dec_inst3,
   output logic [$clog2(DEPTH):0]   fq_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 4);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("ace_fetch_queue: DEPTH must be a power of two and at least 4");
   end

   logic [FW-1:0] mem [DEPTH];
   logic [PW-1:0] hd;
   logic [PW-1:0] tl;
   logic [CW-1:0] cnt;

   logic [FW-1:0] in_inst [4];
   logic [FW-1:0] rd_inst [4];
   logic [2:0]    n_push;
   logic [2:0]    n_avail;
   logic [2:0]    n_pop;
   logic          push_en;

   assign in_inst[0] = fq_in_inst0;
   assign in_inst[1] = fq_in_inst1;
   assign in_inst[2] = fq_in_inst2;
   assign in_inst[3] = fq_in_inst3;

   // Only the contiguous run of valids starting at slot 0 is accepted.
   always_comb begin
      n_push = 3'd0;
      casez (fq_in_valid)
         4'b1111: n_push = 3'd4;
         4'b?111: n_push = 3'd3;
         4'b??11: n_push = 3'd2;
         4'b???1: n_push = 3'd1;
         default: n_push = 3'd0;
      endcase
   end

   assign fq_ready = (cnt <= READY_MAX);
   assign n_avail  = (cnt >= CW'(4)) ? 3'd4 : cnt[2:0];
   assign n_pop    = dec_ready ? n_avail : 3'd0;
   assign push_en  = fq_ready && !fq_flush;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hd  <= '0;
         tl  <= '0;
         cnt <= '0;
      end else if (fq_flush) begin
         hd  <= '0;
         tl  <= '0;
         cnt <= '0;
      end else begin
         hd  <= hd + PW'(n_pop);
         if (push_en) begin
            tl <= tl + PW'(n_push);
         end
         cnt <= cnt + (push_en ? CW'(n_push) : CW'(0)) - CW'(n_pop);
      end
   end

   // Storage is intentionally unreset; every read is masked by its valid bit.
   always_ff @(posedge clk) begin
      if (push_en) begin
         for (int k = 0; k < 4; k++) begin
            if (3'(k) < n_push) begin
               mem[tl + PW'(k)] <= in_inst[k];
            end
         end
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_rd
      assign dec_valid[k] = (3'(k) < n_avail);
      assign rd_inst[k]   = dec_valid[k] ? mem[hd + PW'(k)] : '0;
   end

   assign dec_inst0 = rd_inst[0];
   assign dec_inst1 = rd_inst[1];
   assign dec_inst2 = rd_inst[2];
   assign dec_inst3 = rd_inst[3];
   assign fq_count  = cnt;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset_n) begin
         assert (cnt <= CW'(DEPTH));
         assert (dec_valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
         assert (!(push_en && !fq_ready));
      end
   end
`endif

endmodule

// File: tb/tb_ace_fetch_queue.sv
// Bench for ace_fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ace_fetch_queue;

   localparam int FW    = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          fq_flush = 1'b0;
   logic [3:0]    fq_in_valid = 4'b0000;
   logic [FW-1:0] fq_in_inst0 = '0;
   logic [FW-1:0] fq_in_inst1 = '0;
   logic [FW-1:0] fq_in_inst2 = '0;
   logic [FW-1:0] fq_in_inst3 = '0;
   logic          dec_ready = 1'b0;
   logic          fq_ready;
   logic [3:0]    dec_valid;
   logic [FW-1:0] dec_inst0;
   logic [FW-1:0] dec_inst1;
   logic [FW-1:0] dec_inst2;
   logic [FW-1:0] dec_inst3;
   logic [$clog2(DEPTH):0] fq_count;

   int n_cmp = 0;
   int n_bad = 0;

   ace_fetch_queue #(.FW(FW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fq_flush    (fq_flush),
      .fq_in_valid (fq_in_valid),
      .fq_in_inst0 (fq_in_inst0),
      .fq_in_inst1 (fq_in_inst1),
      .fq_in_inst2 (fq_in_inst2),
      .fq_in_inst3 (fq_in_inst3),
      .fq_ready    (fq_ready),
      .dec_ready   (dec_ready),
      .dec_valid   (dec_valid),
      .dec_inst0   (dec_inst0),
      .dec_inst1   (dec_inst1),
      .dec_inst2   (dec_inst2),
      .dec_inst3   (dec_inst3),
      .fq_count    (fq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: the queue contents, oldest first.
   logic [FW-1:0] mq [$];

   always @(negedge reset_n) mq.delete();

   always @(posedge clk) begin : model
      int sz;
      int np;
      int npop;
      logic [FW-1:0] grp [4];
      if (reset_n) begin
         sz = mq.size();
         grp = '{fq_in_inst0, fq_in_inst1, fq_in_inst2, fq_in_inst3};
         if (fq_flush) begin
            mq.delete();
         end else begin
            np = 0;
            while (np < 4 && fq_in_valid[np]) np++;
            npop = dec_ready ? ((sz < 4) ? sz : 4) : 0;
            for (int k = 0; k < npop; k++) void'(mq.pop_front());
            if (sz <= DEPTH - 4) begin
               for (int k = 0; k < np; k++) mq.push_back(grp[k]);
            end
         end
      end
   end

   always @(negedge clk) begin : cmp
      int sz;
      logic [3:0]    ev;
      logic [FW-1:0] ei [4];
      logic [FW-1:0] ai [4];
      sz = mq.size();
      ev = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         ev[k] = (k < sz);
         ei[k] = ev[k] ? mq[k] : '0;
      end
      ai = '{dec_inst0, dec_inst1, dec_inst2, dec_inst3};
      chk("dec_valid", 32'(dec_valid), 32'(ev));
      chk("fq_count", 32'(fq_count), 32'(sz));
      chk("fq_ready", 32'(fq_ready), 32'(sz <= DEPTH - 4));
      for (int k = 0; k < 4; k++) chk($sformatf("dec_inst%0d", k), 32'(ai[k]), 32'(ei[k]));
   end

   task automatic step(input logic fl, input logic [3:0] v,
                       input logic [FW-1:0] a, input logic [FW-1:0] b,
                       input logic [FW-1:0] c, input logic [FW-1:0] d,
                       input logic rdy);
      fq_flush    = fl;
      fq_in_valid = v;
      fq_in_inst0 = a;
      fq_in_inst1 = b;
      fq_in_inst2 = c;
      fq_in_inst3 = d;
      dec_ready   = rdy;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset while five entries are queued
      step(0, 4'b1111, 16'h0101, 16'h0102, 16'h0103, 16'h0104, 0);
      step(0, 4'b0001, 16'h0105, 16'h0000, 16'h0000, 16'h0000, 0);
      chk("pre_reset_count", 32'(fq_count), 32'd5);
      fq_in_valid = 4'b0000;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_valid", 32'(dec_valid), 32'h0);
      chk("rst_count", 32'(fq_count), 32'd0);
      chk("rst_ready", 32'(fq_ready), 32'd1);
      chk("rst_inst0", 32'(dec_inst0), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      step(0, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 0);
      chk("first_valid", 32'(dec_valid), 32'hF);
      chk("first_inst0", 32'(dec_inst0), 32'hA000);
      chk("first_inst1", 32'(dec_inst1), 32'hA001);
      chk("first_inst2", 32'(dec_inst2), 32'hA002);
      chk("first_inst3", 32'(dec_inst3), 32'hA003);

      // Fill to full, then a third group must be dropped
      step(0, 4'b1111, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 0);
      chk("full_count", 32'(fq_count), 32'd8);
      chk("full_ready", 32'(fq_ready), 32'd0);
      step(0, 4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 0);
      chk("drop_count", 32'(fq_count), 32'd8);
      step(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
      chk("drain1_count", 32'(fq_count), 32'd4);
      chk("drain1_ready", 32'(fq_ready), 32'd1);
      chk("drain1_inst0", 32'(dec_inst0), 32'hB000);
      step(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
      chk("drain2_valid", 32'(dec_valid), 32'h0);

      // Partial groups; bits above the first zero valid are ignored
      step(0, 4'b0011, 16'hC100, 16'hC101, 16'hDEAD, 16'hDEAD, 0);
      step(0, 4'b1011, 16'hC102, 16'hC103, 16'hDEAD, 16'hC1FF, 0);
      chk("part_count", 32'(fq_count), 32'd4);
      chk("part_inst0", 32'(dec_inst0), 32'hC100);
      chk("part_inst1", 32'(dec_inst1), 32'hC101);
      chk("part_inst2", 32'(dec_inst2), 32'hC102);
      chk("part_inst3", 32'(dec_inst3), 32'hC103);
      step(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
      chk("part_drain_count", 32'(fq_count), 32'd0);

      // Move head to 5, then build six entries straddling the end of storage
      step(0, 4'b0001, 16'hD000, 16'h0, 16'h0, 16'h0, 0);
      step(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
      step(0, 4'b1111, 16'hE000, 16'hE001, 16'hE002, 16'hE003, 0);
      step(0, 4'b0011, 16'hE004, 16'hE005, 16'h0, 16'h0, 0);
      chk("wrap_count", 32'(fq_count), 32'd6);
      chk("wrap_ready", 32'(fq_ready), 32'd0);
      chk("wrap_inst0", 32'(dec_inst0), 32'hE000);
      chk("wrap_inst3", 32'(dec_inst3), 32'hE003);
      // With six queued the push is refused (eligibility ignores the same-cycle pop)
      step(0, 4'b0001, 16'hE006, 16'h0, 16'h0, 16'h0, 1);
      chk("wrap_pop_count", 32'(fq_count), 32'd2);
      chk("short_valid", 32'(dec_valid), 32'h3);
      chk("short_inst0", 32'(dec_inst0), 32'hE004);
      chk("short_inst1", 32'(dec_inst1), 32'hE005);
      chk("short_inst2", 32'(dec_inst2), 32'h0);
      step(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
      chk("short_after_valid", 32'(dec_valid), 32'h0);
      chk("short_after_count", 32'(fq_count), 32'd0);

      // Flush colliding with push and pop
      step(0, 4'b1111, 16'hF000, 16'hF001, 16'hF002, 16'hF003, 0);
      step(0, 4'b0001, 16'hF004, 16'h0, 16'h0, 16'h0, 0);
      chk("preflush_count", 32'(fq_count), 32'd5);
      step(1, 4'b1111, 16'hF005, 16'hF006, 16'hF007, 16'hF008, 1);
      chk("flush_count", 32'(fq_count), 32'd0);
      chk("flush_valid", 32'(dec_valid), 32'h0);
      chk("flush_ready", 32'(fq_ready), 32'd1);
      step(0, 4'b0001, 16'hF009, 16'h0, 16'h0, 16'h0, 0);
      chk("postflush_valid", 32'(dec_valid), 32'h1);
      chk("postflush_inst0", 32'(dec_inst0), 32'hF009);
      chk("postflush_inst1", 32'(dec_inst1), 32'h0);

      // Steady state: four in, four out each cycle with occupancy held at 4
      step(1, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0);
      step(0, 4'b1111, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 0);
      for (int i = 1; i < 5; i++) begin
         step(0, 4'b1111, FW'(16'h1000 + i * 16), FW'(16'h1001 + i * 16),
              FW'(16'h1002 + i * 16), FW'(16'h1003 + i * 16), 1);
      end
      chk("steady_count", 32'(fq_count), 32'd4);
      chk("steady_inst0", 32'(dec_inst0), 32'h1040);
      chk("steady_inst3", 32'(dec_inst3), 32'h1043);
      step(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1);
      step(0, 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 0);
      chk("end_count", 32'(fq_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
